// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline hazard controller: load-use stall, branch flush,
//            call/ret wait sequence and halt drain for a 5-stage pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CTRL_LAT  = 2,
    parameter int DRAIN_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] IFID_rs1,
    input  logic [3:0] IFID_rs2,
    input  logic       IFID_uses_rs1,
    input  logic       IFID_uses_rs2,
    input  logic       IDEX_MemRead,
    input  logic       IDEX_RegWrite,
    input  logic [3:0] IDEX_reg_rd,
    input  logic       ID_call,
    input  logic       ID_ret,
    input  logic       ID_halt,
    input  logic       EX_br_taken,
    output logic       PC_stall,
    output logic       IFID_stall,
    output logic       IFID_flush,
    output logic       IDEX_bubble,
    output logic       PC_hazard,
    output logic       halted
);

    localparam logic [2:0] c_ctrl_lat  = 3'(CTRL_LAT);
    localparam logic [2:0] c_drain_lat = 3'(DRAIN_LAT);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        CTRL_WAIT  = 2'd1,
        HALT_DRAIN = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_next;

    logic w_load_use;
    logic w_pc_stall;
    logic w_ifid_stall;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_pc_hazard;
    logic w_halted;

    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign w_load_use = IDEX_MemRead & IDEX_RegWrite & (IDEX_reg_rd != 4'd0) &
                        ((IFID_uses_rs1 & (IFID_rs1 == IDEX_reg_rd)) |
                         (IFID_uses_rs2 & (IFID_rs2 == IDEX_reg_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pc_hazard   = 1'b0;
        w_halted      = 1'b0;

        case (r_state)
            RUN: begin
                if (EX_br_taken) begin
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                end else if (w_load_use) begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_bubble = 1'b1;
                end else if (ID_halt) begin
                    // HALT itself must reach ID/EX, so no bubble on entry.
                    w_pc_stall   = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_state_next = HALT_DRAIN;
                    w_cnt_next   = c_drain_lat;
                end else if (ID_call | ID_ret) begin
                    w_pc_stall   = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_pc_hazard  = 1'b1;
                    w_state_next = CTRL_WAIT;
                    w_cnt_next   = c_ctrl_lat;
                end
            end

            CTRL_WAIT: begin
                w_pc_stall    = 1'b1;
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
                w_pc_hazard   = 1'b1;
                w_cnt_next    = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_next = RUN;
                    w_cnt_next   = 3'd0;
                end
            end

            HALT_DRAIN: begin
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
                if (EX_br_taken) begin
                    // An older branch resolved taken: the HALT was on the wrong path.
                    w_state_next = RUN;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_pc_stall = 1'b1;
                    w_cnt_next = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_state_next = HALTED;
                        w_cnt_next   = 3'd0;
                    end
                end
            end

            HALTED: begin
                w_halted      = 1'b1;
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_bubble = 1'b1;
            end

            default: begin
                w_state_next = RUN;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    assign PC_stall    = w_pc_stall    & ~rst;
    assign IFID_stall  = w_ifid_stall  & ~rst;
    assign IFID_flush  = w_ifid_flush  & ~rst;
    assign IDEX_bubble = w_idex_bubble & ~rst;
    assign PC_hazard   = w_pc_hazard   & ~rst;
    assign halted      = w_halted      & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] IFID_rs1, IFID_rs2, IDEX_reg_rd;
    logic       IFID_uses_rs1, IFID_uses_rs2;
    logic       IDEX_MemRead, IDEX_RegWrite;
    logic       ID_call, ID_ret, ID_halt, EX_br_taken;
    logic       PC_stall, IFID_stall, IFID_flush, IDEX_bubble, PC_hazard, halted;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.CTRL_LAT(2), .DRAIN_LAT(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .IFID_rs1      (IFID_rs1),
        .IFID_rs2      (IFID_rs2),
        .IFID_uses_rs1 (IFID_uses_rs1),
        .IFID_uses_rs2 (IFID_uses_rs2),
        .IDEX_MemRead  (IDEX_MemRead),
        .IDEX_RegWrite (IDEX_RegWrite),
        .IDEX_reg_rd   (IDEX_reg_rd),
        .ID_call       (ID_call),
        .ID_ret        (ID_ret),
        .ID_halt       (ID_halt),
        .EX_br_taken   (EX_br_taken),
        .PC_stall      (PC_stall),
        .IFID_stall    (IFID_stall),
        .IFID_flush    (IFID_flush),
        .IDEX_bubble   (IDEX_bubble),
        .PC_hazard     (PC_hazard),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {PC_stall, IFID_stall, IFID_flush, IDEX_bubble, PC_hazard, halted}
    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        #3;
        obs = {PC_stall, IFID_stall, IFID_flush, IDEX_bubble, PC_hazard, halted};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IFID_rs1 = 4'd0; IFID_rs2 = 4'd0; IDEX_reg_rd = 4'd0;
        IFID_uses_rs1 = 1'b0; IFID_uses_rs2 = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0;
        ID_call = 1'b0; ID_ret = 1'b0; ID_halt = 1'b0; EX_br_taken = 1'b0;
    endtask

    task automatic load_use(input logic [3:0] rd, input logic [3:0] rs1, input logic u1,
                            input logic [3:0] rs2, input logic u2);
        IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_reg_rd = rd;
        IFID_rs1 = rs1; IFID_uses_rs1 = u1;
        IFID_rs2 = rs2; IFID_uses_rs2 = u2;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        // Reset with a live load-use hazard on the inputs: outputs forced low.
        load_use(4'd5, 4'd5, 1'b1, 4'd0, 1'b0);
        chk("reset_outputs", 6'b000000);
        cyc();
        rst = 1'b0; idle();
        chk("idle_run", 6'b000000);
        cyc();

        // Load-use on rs1: exactly one stall cycle once the hazard clears.
        load_use(4'd5, 4'd5, 1'b1, 4'd0, 1'b0);
        chk("loaduse_rs1", 6'b110100);
        cyc(); idle();
        chk("loaduse_one_cycle", 6'b000000);
        cyc();
        load_use(4'd0, 4'd0, 1'b1, 4'd0, 1'b1);
        chk("loaduse_r0", 6'b000000);
        cyc();
        load_use(4'd7, 4'd7, 1'b0, 4'd3, 1'b1);
        chk("rs1_unused", 6'b000000);
        cyc();
        load_use(4'd7, 4'd1, 1'b1, 4'd7, 1'b1);
        chk("loaduse_rs2", 6'b110100);
        cyc();
        IDEX_MemRead = 1'b0;
        chk("no_memread", 6'b000000);
        cyc(); idle();

        // Branch beats load-use.
        load_use(4'd5, 4'd5, 1'b1, 4'd0, 1'b0);
        EX_br_taken = 1'b1;
        chk("branch_vs_stall", 6'b001100);
        cyc(); idle();

        // Call with CTRL_LAT=2; a branch during the wait is ignored.
        ID_call = 1'b1;
        chk("call_entry", 6'b101010);
        cyc(); idle();
        EX_br_taken = 1'b1;
        chk("call_wait1", 6'b101110);
        cyc(); idle();
        chk("call_wait2", 6'b101110);
        cyc();
        chk("call_back_run", 6'b000000);
        cyc();

        // call and ret together behave as one event.
        ID_call = 1'b1; ID_ret = 1'b1;
        chk("callret_entry", 6'b101010);
        cyc(); idle();
        chk("callret_wait1", 6'b101110);
        cyc();
        chk("callret_wait2", 6'b101110);
        cyc();
        chk("callret_run", 6'b000000);
        cyc();

        // Branch squashes halt; load-use outranks halt.
        ID_halt = 1'b1; EX_br_taken = 1'b1;
        chk("branch_squash_halt", 6'b001100);
        cyc(); EX_br_taken = 1'b0;
        load_use(4'd2, 4'd2, 1'b1, 4'd0, 1'b0);
        chk("loaduse_over_halt", 6'b110100);
        cyc();
        IDEX_MemRead = 1'b0;
        ID_call = 1'b1;
        chk("halt_over_call", 6'b101000);
        cyc(); idle();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("halt_drain%0d", i + 1), 6'b101100);
            cyc();
        end
        for (int i = 0; i < 12; i++) begin
            EX_br_taken = (i == 4);
            ID_call     = (i == 6);
            chk($sformatf("halted_hold%0d", i), 6'b110101);
            cyc();
        end
        idle();
        rst = 1'b1;
        chk("rst_from_halted", 6'b000000);
        cyc();
        rst = 1'b0;
        chk("run_after_halted", 6'b000000);
        cyc();

        // Halt cancelled by an older branch in the second drain cycle.
        ID_halt = 1'b1;
        chk("cancel_entry", 6'b101000);
        cyc(); idle();
        chk("cancel_drain1", 6'b101100);
        cyc();
        EX_br_taken = 1'b1;
        chk("cancel_drain2_br", 6'b001100);
        cyc(); idle();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("cancel_run%0d", i), 6'b000000);
            cyc();
        end

        // Reset in the second CTRL_WAIT cycle aborts the sequence.
        ID_call = 1'b1;
        chk("rstwait_entry", 6'b101010);
        cyc(); idle();
        chk("rstwait_wait1", 6'b101110);
        cyc();
        rst = 1'b1;
        chk("rstwait_in_rst", 6'b000000);
        cyc();
        rst = 1'b0;
        chk("rstwait_after1", 6'b000000);
        cyc();
        chk("rstwait_after2", 6'b000000);
        cyc();

        // Reset mid-drain likewise leaves no residue.
        ID_halt = 1'b1;
        chk("rstdrain_entry", 6'b101000);
        cyc(); idle();
        rst = 1'b1;
        chk("rstdrain_in_rst", 6'b000000);
        cyc();
        rst = 1'b0;
        chk("rstdrain_after", 6'b000000);
        cyc();
        chk("rstdrain_after2", 6'b000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
